// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // One buffered fetch result: the PC it was fetched from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and a registered head entry.
// The head register always holds the entry at the read pointer, so the
// consumer sees flop outputs with no read mux in front of it.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push;
  logic             do_pop;

  // Next-state for storage, pointers, occupancy and the head register; flush wins.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    head_d = mem_d[rd_ptr_d];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues word fetches to a 1-cycle-latency
// instruction memory, buffers responses and hands {pc, instr} to decode.
// Redirects flush the buffer and drop any response arriving that cycle.
module instr_fetch_stage #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;
  logic             accept;
  logic [OCC_W-1:0] occupancy;

  // Handshakes and issue credit: only fetch when the buffer is guaranteed room.
  always_comb begin
    out_valid        = (fifo_count != '0) && !redirect_valid;
    pop              = out_valid && out_ready;
    occupancy        = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);
    imem_req_valid   = !redirect_valid && (occupancy < OCC_W'(FIFO_DEPTH));
    accept           = imem_req_valid && imem_req_ready;
    push             = imem_rsp_valid && inflight_q && !redirect_valid;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = imem_rsp_data;
  end

  // Next PC and in-flight tracking; a redirect overrides sequential fetch.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = accept;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~WIDTH'(3);
    end else if (accept) begin
      pc_d          = pc_q + WIDTH'(INSTR_BYTES);
      inflight_pc_d = pc_q;
    end
  end

  // PC and in-flight registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_req_addr = pc_q;
  assign out_pc        = fifo_head.pc;
  assign out_instr     = fifo_head.instr;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a memory model answers accepted fetches,
// a reference stream of expected {pc, instr} is queued whenever the
// program flow is (re)started, and a monitor compares every decode handshake.
module tb_instr_fetch_stage;

  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2  = '0;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pops  = 0;
  int          n2    = 0;
  logic        spurious_en = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] gen_pc       = RST_PC;
  logic [31:0] exp_fetch_pc = RST_PC;
  logic        prev_reset   = 1'b0;
  logic        prev_stall   = 1'b0;
  logic [31:0] prev_pc      = '0;
  logic [31:0] prev_instr   = '0;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .WIDTH      (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  instr_fetch_stage #(
    .WIDTH      (32),
    .RESET_PC   (RST_PC2),
    .FIFO_DEPTH (2)
  ) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (req_valid2),
    .imem_req_ready (1'b1),
    .imem_req_addr  (req_addr2),
    .imem_rsp_valid (rsp_valid2),
    .imem_rsp_data  (rsp_data2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_pc         (out_pc2),
    .out_instr      (out_instr2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rrdy, input logic ordy,
                               input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset          = rst;
    imem_req_ready = rrdy;
    out_ready      = ordy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // Instruction memory: answers every accepted fetch one cycle later with addr ^ KEY.
  always @(posedge clk) begin : mem_model
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    #1;
    imem_rsp_valid = acc || (spurious_en && ($urandom_range(0, 7) == 0));
    imem_rsp_data  = acc ? (a ^ KEY) : $urandom;
  end

  // Memory for the wrap-around instance, always ready.
  always @(posedge clk) begin : mem_model2
    logic        acc;
    logic [31:0] a;
    acc = req_valid2;
    a   = req_addr2;
    #1;
    rsp_valid2 = acc;
    rsp_data2  = acc ? (a ^ KEY) : 32'hDEAD_BEEF;
  end

  // Scoreboard monitor: checks every handshake, fetch address and stall/redirect rule.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (!prev_reset) begin
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("rst_req_addr", imem_req_addr, RST_PC);
      end
      if (redirect_valid) begin
        checkOutput("redir_out_valid", 32'(out_valid), 32'd0);
        checkOutput("redir_req_valid", 32'(imem_req_valid), 32'd0);
      end
      if (prev_stall) begin
        checkOutput("stall_pc", out_pc, prev_pc);
        checkOutput("stall_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checkOutput("out_pc", out_pc, e.pc);
        checkOutput("out_instr", out_instr, e.instr);
        pops++;
      end
      if (imem_req_valid && imem_req_ready) begin
        checkOutput("fetch_addr", imem_req_addr, exp_fetch_pc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        gen_pc       = redirect_pc & ~32'h3;
        exp_fetch_pc = gen_pc;
      end
    end else begin
      exp_q.delete();
      gen_pc       = RST_PC;
      exp_fetch_pc = RST_PC;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(exp_t'{pc: gen_pc, instr: gen_pc ^ KEY});
      gen_pc = gen_pc + 32'd4;
    end
    prev_stall = reset && out_valid && !out_ready;
    prev_pc    = out_pc;
    prev_instr = out_instr;
    prev_reset = reset;
  end

  // Wrap-around instance: first three entries after reset must straddle 2^32.
  always @(negedge clk) begin
    if (reset && out_valid2 && n2 < 3) begin
      checkOutput("wrap_pc", out_pc2, RST_PC2 + 32'(4 * n2));
      checkOutput("wrap_instr", out_instr2, (RST_PC2 + 32'(4 * n2)) ^ KEY);
      n2++;
    end
  end

  // Directed phases followed by a randomized stretch.
  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 1, 0, 0);
      @(negedge clk);
      checkOutput("latency_valid", 32'(out_valid), (k >= 2) ? 32'd1 : 32'd0);
    end

    applyStimulus(1, 1, 1, 1, 32'h0000_0103);
    applyStimulus(1, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("redir_next_req", 32'(imem_req_valid), 32'd1);
    checkOutput("redir_next_addr", imem_req_addr, 32'h0000_0100);
    repeat (6) applyStimulus(1, 1, 1, 0, 0);

    applyStimulus(0, 1, 0, 0, 0);
    repeat (10) applyStimulus(1, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("full_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_head_pc", out_pc, 32'd0);
    checkOutput("full_head_instr", out_instr, KEY);
    repeat (6) applyStimulus(1, 1, 1, 0, 0);

    repeat (4) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 32'h0000_0203);
    repeat (6) applyStimulus(1, 1, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, (i % 2) == 0, 1, 0, 0);
    end

    spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 19) == 0, $urandom);
    end
    spurious_en = 1'b0;

    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    repeat (6) applyStimulus(1, 1, 1, 0, 0);

    @(negedge clk);
    checkOutput("wrap_count", 32'(n2), 32'd3);
    checkOutput("pops_seen", 32'(pops > 50), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
